// File: rtl/vga_stream_probe_pkg.sv
// vga_stream_probe_pkg: stream timing constants, probe FSM states and a saturating add helper
package vga_stream_probe_pkg;
  localparam int HOR_TOTAL_TIME  = 1056;
  localparam int VER_TOTAL_TIME  = 628;
  localparam int HOR_ACTIVE_TIME = 800;
  localparam int VER_ACTIVE_TIME = 600;

  typedef enum logic [1:0] {PR_IDLE, PR_WAIT_SOF, PR_ARMED} probe_state_t;

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {7'd0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction
endpackage

// File: rtl/vga_stream_probe_if.sv
// vga_stream_probe_if: pixel stream bundle between the drawing chain and the VGA pins
interface vga_stream_probe_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        hblnk;
  logic        vsync;
  logic        vblnk;
  logic [11:0] rgb;
  modport master(output hcount, vcount, hsync, hblnk, vsync, vblnk, rgb);
  modport slave(input hcount, vcount, hsync, hblnk, vsync, vblnk, rgb);
endinterface

// File: rtl/vga_stream_probe_shadow_cnt.sv
// vga_stream_probe_shadow_cnt: free-running h/v shadow that locks at the stream origin and flags divergence
module vga_stream_probe_shadow_cnt
  import vga_stream_probe_pkg::*;
#(
  parameter int H_TOTAL = HOR_TOTAL_TIME,
  parameter int V_TOTAL = VER_TOTAL_TIME
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic [10:0] i_h,
  input  logic [10:0] i_v,
  output logic        o_origin,
  output logic        o_locked,
  output logic        o_mismatch
);
  logic        r_locked;
  logic [10:0] r_h, r_v;
  logic        w_hwrap;
  logic [10:0] w_nh, w_nv;

  // r_h/r_v hold the last position seen; the incoming pixel must equal its successor
  assign w_hwrap    = r_h == 11'(H_TOTAL - 1);
  assign w_nh       = w_hwrap ? '0 : r_h + 11'd1;
  assign w_nv       = !w_hwrap ? r_v : (r_v == 11'(V_TOTAL - 1)) ? '0 : r_v + 11'd1;
  assign o_origin   = i_valid && i_h == '0 && i_v == '0;
  assign o_mismatch = r_locked && i_valid && (i_h != w_nh || i_v != w_nv);
  assign o_locked   = r_locked;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_locked <= 1'b0;
      r_h      <= '0;
      r_v      <= '0;
    end else if (o_mismatch) begin
      r_locked <= 1'b0;
    end else if (r_locked && i_valid) begin
      r_h <= w_nh;
      r_v <= w_nv;
    end else if (o_origin) begin
      r_locked <= 1'b1;
      r_h      <= '0;
      r_v      <= '0;
    end
  end
endmodule

// File: rtl/vga_stream_probe.sv
// vga_stream_probe: passive stream checker with timing lock, blank-rgb check, frame checksum and pixel probe
module vga_stream_probe
  import vga_stream_probe_pkg::*;
#(
  parameter int H_TOTAL  = HOR_TOTAL_TIME,
  parameter int V_TOTAL  = VER_TOTAL_TIME,
  parameter int H_ACTIVE = HOR_ACTIVE_TIME,
  parameter int V_ACTIVE = VER_ACTIVE_TIME
) (
  input  logic                clk,
  input  logic                rst,
  vga_stream_probe_if.slave   i_vga,
  input  logic                i_probe_req,
  input  logic [10:0]         i_probe_x,
  input  logic [10:0]         i_probe_y,
  output logic                o_probe_busy,
  output logic                o_probe_valid,
  output logic                o_probe_err,
  output logic [11:0]         o_probe_rgb,
  output logic                o_locked,
  output logic                o_timing_err,
  output logic [7:0]          o_err_count,
  output logic [15:0]         o_frame_sum,
  output logic                o_frame_sum_valid
);
  logic         r_s_valid, r_s_hb, r_s_vb;
  logic [10:0]  r_s_h, r_s_v;
  logic [11:0]  r_s_rgb;
  logic         w_origin, w_locked, w_mis, w_blank_err, w_active, w_pub;
  logic         r_timing_err, r_arm, r_fsum_valid;
  logic [7:0]   r_err_count;
  logic [15:0]  r_acc, r_fsum;
  probe_state_t r_state, w_next;
  logic [10:0]  r_x, r_y;
  logic         w_hit, w_sof, w_req_ok, w_take, w_err_n;
  logic         r_busy, r_pvalid, r_perr;
  logic [11:0]  r_prgb;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s_valid <= 1'b0;
      r_s_h     <= '0;
      r_s_v     <= '0;
      r_s_hb    <= 1'b0;
      r_s_vb    <= 1'b0;
      r_s_rgb   <= '0;
    end else begin
      r_s_valid <= 1'b1;
      r_s_h     <= i_vga.hcount;
      r_s_v     <= i_vga.vcount;
      r_s_hb    <= i_vga.hblnk;
      r_s_vb    <= i_vga.vblnk;
      r_s_rgb   <= i_vga.rgb;
    end
  end

  vga_stream_probe_shadow_cnt #(.H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL)) u_shadow (
    .clk(clk), .rst(rst), .i_valid(r_s_valid), .i_h(r_s_h), .i_v(r_s_v),
    .o_origin(w_origin), .o_locked(w_locked), .o_mismatch(w_mis)
  );

  assign w_blank_err = r_s_valid && (r_s_hb || r_s_vb) && r_s_rgb != '0;
  assign w_active    = r_s_valid && !r_s_hb && !r_s_vb;
  // a frame is published only if lock held from its opening origin to its closing one
  assign w_pub       = w_origin && !w_mis && r_arm;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_timing_err <= 1'b0;
      r_err_count  <= '0;
      r_acc        <= '0;
      r_arm        <= 1'b0;
      r_fsum       <= '0;
      r_fsum_valid <= 1'b0;
    end else begin
      r_timing_err <= r_timing_err | w_mis;
      r_err_count  <= sat_add(r_err_count, {1'b0, w_mis} + {1'b0, w_blank_err});
      r_acc        <= (w_origin ? 16'd0 : r_acc) + (w_active ? {4'd0, r_s_rgb} : 16'd0);
      r_arm        <= w_mis ? 1'b0 : w_origin ? 1'b1 : r_arm;
      r_fsum       <= w_pub ? r_acc : r_fsum;
      r_fsum_valid <= w_pub;
    end
  end

  assign w_req_ok = i_probe_req && i_probe_x < 11'(H_ACTIVE) && i_probe_y < 11'(V_ACTIVE);
  assign w_hit    = r_s_valid && r_s_h == r_x && r_s_v == r_y;
  assign w_sof    = w_origin && w_locked && !w_mis;
  // a probe of (0,0) completes on the very origin that would arm it
  assign w_take   = w_hit && ((r_state == PR_ARMED && !w_mis) || (r_state == PR_WAIT_SOF && w_sof));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= PR_IDLE;
      r_x      <= '0;
      r_y      <= '0;
      r_busy   <= 1'b0;
      r_pvalid <= 1'b0;
      r_perr   <= 1'b0;
      r_prgb   <= '0;
    end else begin
      r_state  <= w_next;
      r_x      <= (r_state == PR_IDLE && w_req_ok) ? i_probe_x : r_x;
      r_y      <= (r_state == PR_IDLE && w_req_ok) ? i_probe_y : r_y;
      r_busy   <= w_next != PR_IDLE;
      r_pvalid <= w_take;
      r_perr   <= w_err_n;
      r_prgb   <= w_take ? r_s_rgb : r_prgb;
    end
  end

  always_comb begin
    w_next = r_state;
    if (r_state == PR_IDLE)
      w_next = w_req_ok ? PR_WAIT_SOF : PR_IDLE;
    else if (w_take)
      w_next = PR_IDLE;
    else if (r_state == PR_WAIT_SOF && w_sof)
      w_next = PR_ARMED;
    else if (r_state == PR_ARMED && w_mis)
      w_next = PR_WAIT_SOF;
  end

  always_comb begin
    w_err_n = r_state == PR_IDLE && i_probe_req && !w_req_ok;
  end

  assign o_probe_busy      = r_busy;
  assign o_probe_valid     = r_pvalid;
  assign o_probe_err       = r_perr;
  assign o_probe_rgb       = r_prgb;
  assign o_locked          = w_locked;
  assign o_timing_err      = r_timing_err;
  assign o_err_count       = r_err_count;
  assign o_frame_sum       = r_fsum;
  assign o_frame_sum_valid = r_fsum_valid;
endmodule

// File: tb/tb_vga_stream_probe.sv
// tb_vga_stream_probe: randomized stream + probe stimulus against a frame-level reference model with scoreboard
module tb_vga_stream_probe;
  localparam int HT = 40, VT = 12, HA = 32, VA = 10;
  typedef struct {int cyc; int val;} ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [10:0] px = '0, py = '0;
  logic        busy, pvalid, perr, locked, terr, fsv;
  logic [11:0] prgb;
  logic [7:0]  errc;
  logic [15:0] fsum;

  vga_stream_probe_if vif();

  vga_stream_probe #(.H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA)) dut (
    .clk(clk), .rst(rst), .i_vga(vif.slave),
    .i_probe_req(req), .i_probe_x(px), .i_probe_y(py),
    .o_probe_busy(busy), .o_probe_valid(pvalid), .o_probe_err(perr), .o_probe_rgb(prgb),
    .o_locked(locked), .o_timing_err(terr), .o_err_count(errc),
    .o_frame_sum(fsum), .o_frame_sum_valid(fsv)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0, cyc = 0;
  bit mon_en = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model: frame-level view of the stream, results visible one cycle after it consumes a pixel
  bit   m_locked = 0, m_terr = 0, m_fok = 0, m_pend = 0, m_armed = 0;
  int   eh = 0, ev = 0, m_errc = 0, m_acc = 0, m_fsum = 0, m_rgb = 0, m_x = 0, m_y = 0;
  bit   p_ok = 0, p_hb, p_vb;
  int   p_h, p_v, p_rgb;
  ev_t  q_sum[$], q_probe[$];
  int   q_err[$];

  always @(posedge clk) begin
    bit was_idle, orig, mis, berr, hit;
    cyc++;
    if (rst) begin
      m_locked = 0; m_terr = 0; m_fok = 0; m_pend = 0; m_armed = 0;
      eh = 0; ev = 0; m_errc = 0; m_acc = 0; m_fsum = 0; m_rgb = 0;
      q_sum.delete(); q_probe.delete(); q_err.delete();
      p_ok = 0;
    end else begin
      was_idle = !m_pend;
      if (p_ok) begin
        orig = p_h == 0 && p_v == 0;
        mis  = m_locked && (p_h != eh || p_v != ev);
        berr = (p_hb || p_vb) && p_rgb != 0;
        m_errc = m_errc + int'(mis) + int'(berr);
        if (m_errc > 255) m_errc = 255;
        if (mis) m_terr = 1;
        if (m_pend) begin
          hit = p_h == m_x && p_v == m_y;
          if (m_armed) begin
            if (mis) m_armed = 0;
            else if (hit) begin q_probe.push_back('{cyc, p_rgb}); m_rgb = p_rgb; m_pend = 0; m_armed = 0; end
          end else if (orig && m_locked && !mis) begin
            if (hit) begin q_probe.push_back('{cyc, p_rgb}); m_rgb = p_rgb; m_pend = 0; end
            else m_armed = 1;
          end
        end
        if (orig) begin
          if (!mis && m_fok) begin q_sum.push_back('{cyc, m_acc}); m_fsum = m_acc; end
          m_acc = 0;
        end
        if (mis) m_fok = 0;
        else if (orig) m_fok = 1;
        if (!p_hb && !p_vb) m_acc = (m_acc + p_rgb) % 65536;
        if (mis) m_locked = 0;
        else if (m_locked || orig) begin
          m_locked = 1;
          eh = (p_h + 1) % HT;
          ev = (p_h == HT - 1) ? (p_v + 1) % VT : p_v;
        end
      end
      if (was_idle && req) begin
        if (px < HA && py < VA) begin m_pend = 1; m_armed = 0; m_x = px; m_y = py; end
        else q_err.push_back(cyc);
      end
      p_ok = 1; p_h = vif.hcount; p_v = vif.vcount; p_hb = vif.hblnk; p_vb = vif.vblnk; p_rgb = vif.rgb;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("locked", locked, m_locked);
      chk("timing_err", terr, m_terr);
      chk("err_count", errc, m_errc);
      chk("probe_busy", busy, m_pend);
      chk("probe_rgb_hold", prgb, m_rgb);
      chk("frame_sum_hold", fsum, m_fsum);
      if (q_sum.size() > 0 && q_sum[0].cyc == cyc) begin
        chk("frame_sum_valid", fsv, 1);
        chk("frame_sum_value", fsum, q_sum[0].val);
        void'(q_sum.pop_front());
      end else chk("frame_sum_valid", fsv, 0);
      if (q_probe.size() > 0 && q_probe[0].cyc == cyc) begin
        chk("probe_valid", pvalid, 1);
        chk("probe_rgb", prgb, q_probe[0].val);
        void'(q_probe.pop_front());
      end else chk("probe_valid", pvalid, 0);
      if (q_err.size() > 0 && q_err[0] == cyc) begin
        chk("probe_err", perr, 1);
        void'(q_err.pop_front());
      end else chk("probe_err", perr, 0);
    end
  end

  // stream generator
  int gh = 0, gv = 0, blank_left = 0, f_x = 0, f_y = 0;
  bit rnd_fill = 0, ov_en = 0, skip = 0, blank_all = 0, prob_en = 0, f_req = 0;

  task automatic drive();
    bit hb, vb;
    hb = gh >= HA;
    vb = gv >= VA;
    vif.hcount = 11'(gh);
    vif.vcount = 11'(gv);
    vif.hblnk  = hb;
    vif.vblnk  = vb;
    vif.hsync  = gh >= HA + 2 && gh < HA + 6;
    vif.vsync  = gv == VA + 1;
    if (hb || vb) begin
      vif.rgb = (blank_all || (hb && blank_left > 0)) ? 12'hFFF : 12'h000;
      if (hb && blank_left > 0) blank_left--;
    end else begin
      vif.rgb = (ov_en && gh == 10 && gv == 5) ? 12'hABC : rnd_fill ? 12'($urandom_range(0, 4095)) : 12'h0F0;
    end
    req = 1'b0;
    if (f_req) begin
      req = 1'b1; px = 11'(f_x); py = 11'(f_y); f_req = 0;
    end else if (prob_en && $urandom_range(0, 99) < 3) begin
      req = 1'b1; px = 11'($urandom_range(0, HA + 3)); py = 11'($urandom_range(0, VA + 2));
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      drive();
      @(posedge clk);
      #1;
      gh++;
      if (skip && gh == 15) begin gh = 16; skip = 0; end
      if (gh == HT) begin gh = 0; gv = (gv + 1) % VT; end
    end
  endtask

  task automatic run_to(input int h, input int v);
    for (int k = 0; k < HT * VT && !(gh == h && gv == v); k++) run(1);
  endtask

  task automatic probe(input int x, input int y);
    f_req = 1; f_x = x; f_y = y;
    run(1);
  endtask

  initial begin
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_locked", locked, 0);
    chk("rst_err_count", errc, 0);
    chk("rst_frame_sum", fsum, 0);
    chk("rst_busy", busy, 0);
    chk("rst_probe_rgb", prgb, 0);
    mon_en = 1;

    run_to(0, 0);
    run(3 * HT * VT);
    @(negedge clk);
    chk("const_frame_sum", fsum, (HA * VA * 240) % 65536);
    chk("const_locked", locked, 1);
    chk("const_err_count", errc, 0);

    rnd_fill = 1; ov_en = 1;
    run(100);
    probe(10, 5);
    run(2 * HT * VT);
    prob_en = 1;
    run(6 * HT * VT);
    prob_en = 0;
    run(2 * HT * VT + 10);

    probe(HA, 0);
    run(2);
    probe(0, VA);
    run(2);
    probe(HA - 1, VA - 1);
    run(2 * HT * VT);

    skip = 1;
    run(3 * HT * VT);
    @(negedge clk);
    chk("skip_timing_err", terr, 1);

    blank_left = 3;
    run(HT * VT);
    blank_all = 1;
    run(2 * HT * VT);
    blank_all = 0;
    run(5);
    @(negedge clk);
    chk("saturated_err_count", errc, 255);

    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run_to(0, 0);
    run(HT * VT);
    run_to(5, 3);
    probe(20, 8);
    run_to(0, 0);
    run(30);
    @(negedge clk);
    chk("armed_busy", busy, 1);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    @(negedge clk);
    chk("midprobe_rst_busy", busy, 0);
    chk("midprobe_rst_frame_sum", fsum, 0);
    chk("midprobe_rst_locked", locked, 0);
    run(2 * HT * VT + 50);
    probe(7, 3);
    run(2 * HT * VT + 50);
    @(negedge clk);
    chk("final_busy", busy, 0);
    chk("final_probe_queue", q_probe.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
